// File: rtl/ldpc_shift_sched.sv
// Layered LDPC shift scheduler: walks the LAYERS x D shift table per iteration and feeds the cyclic shifter.
// Optional build macro SKIP_NULL_EN: null (all-ones) entries are stepped over instead of issued.
module ldpc_shift_sched #(
  parameter int DATA_W   = 8,
  parameter int D        = 5,
  parameter int LAYERS   = 4,
  parameter int MAX_ITER = 10,
  parameter int AW       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_err,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [7:0]        iter_cnt,
  output logic [DATA_W-1:0] shift_out,
  output logic              shift_valid,
  input  logic              shift_ready,
  output logic [AW-1:0]     layer_idx,
  output logic [AW-1:0]     col_idx,
  output logic              layer_last,
  input  logic              syn_valid,
  input  logic              syn_ok
);

  localparam int N = LAYERS * D;
  localparam logic [DATA_W-1:0] NULLV = '1;

  typedef enum logic [1:0] {IDLE, RUN, WAIT_SYN, FIN} state_t;
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [AW-1:0] ly;
    logic [AW-1:0] cl;
  } pos_t;

  state_t            state;
  logic [DATA_W-1:0] tbl [N];
  logic [AW-1:0]     cur;
  logic [N-1:0]      use_e;
  pos_t              p0, pn, ld;
  logic              p0_found, pn_found, load_en;
  logic              addr_ok, data_bad, last_iter;

  assign addr_ok   = {1'b0, cfg_addr} < (AW+1)'(N);
  assign data_bad  = (cfg_data != NULLV) && ((cfg_data >> 2) >= DATA_W'(D));
  assign last_iter = iter_cnt == 8'(MAX_ITER - 1);

  always_comb begin
    for (int i = 0; i < N; i++) begin
`ifdef SKIP_NULL_EN
      use_e[i] = tbl[i] != NULLV;
`else
      use_e[i] = 1'b1;
`endif
    end
  end

  // Priority search from the top down: the last hit is the lowest usable index.
  always_comb begin
    p0_found = 1'b0;
    pn_found = 1'b0;
    p0       = '0;
    pn       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (use_e[i]) begin
        p0_found = 1'b1;
        p0       = '{AW'(i), AW'(i / D), AW'(i % D)};
        if (i > int'(cur)) begin
          pn_found = 1'b1;
          pn       = '{AW'(i), AW'(i / D), AW'(i % D)};
        end
      end
    end
  end

  always_comb begin
    ld      = (state == RUN) ? pn : p0;
    load_en = 1'b0;
    case (state)
      IDLE:     load_en = start && p0_found;
      RUN:      load_en = !abort && shift_ready && pn_found;
      WAIT_SYN: load_en = !abort && syn_valid && !syn_ok && !last_iter && p0_found;
      default:  load_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) tbl[i] <= NULLV;
    end else if (state == IDLE && cfg_we && !start && addr_ok) begin
      tbl[cfg_addr] <= data_bad ? NULLV : cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      cfg_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      iter_cnt    <= '0;
      shift_out   <= '0;
      shift_valid <= 1'b0;
      layer_idx   <= '0;
      col_idx     <= '0;
      layer_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_we && (state != IDLE || start || !addr_ok || data_bad)) cfg_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          cfg_err   <= cfg_we;
          converged <= 1'b0;
          iter_cnt  <= '0;
          busy      <= 1'b1;
          layer_idx <= '0;
          col_idx   <= '0;
          state     <= p0_found ? RUN : WAIT_SYN;
        end
        RUN: if (abort) begin
          state       <= FIN;
          done        <= 1'b1;
          busy        <= 1'b0;
          converged   <= 1'b0;
          shift_valid <= 1'b0;
        end else if (shift_ready && !pn_found) begin
          state       <= WAIT_SYN;
          shift_valid <= 1'b0;
        end
        WAIT_SYN: if (abort || (syn_valid && (syn_ok || last_iter))) begin
          state     <= FIN;
          done      <= 1'b1;
          busy      <= 1'b0;
          converged <= !abort && syn_ok;
        end else if (syn_valid) begin
          iter_cnt  <= iter_cnt + 8'd1;
          layer_idx <= '0;
          col_idx   <= '0;
          if (p0_found) state <= RUN;
        end
        default: state <= IDLE;
      endcase
      // Loads the next issued entry; overrides the column/layer clears above.
      if (load_en) begin
        cur         <= ld.idx;
        shift_out   <= tbl[ld.idx];
        layer_idx   <= ld.ly;
        col_idx     <= ld.cl;
        layer_last  <= ld.cl == AW'(D - 1);
        shift_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_shift_sched.sv
// Randomized bench for ldpc_shift_sched with a table/queue reference model and a per-cycle issue monitor.
module tb_ldpc_shift_sched;
  localparam int DATA_W = 8, D = 5, LAYERS = 4, MAX_ITER = 10, AW = 5, N = LAYERS * D;
`ifdef SKIP_NULL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk, rst_n, cfg_we, cfg_err, start, abort, busy, done, converged;
  logic [AW-1:0] cfg_addr, layer_idx, col_idx;
  logic [DATA_W-1:0] cfg_data, shift_out;
  logic [7:0] iter_cnt;
  logic shift_valid, shift_ready, layer_last, syn_valid, syn_ok;

  ldpc_shift_sched #(.DATA_W(DATA_W), .D(D), .LAYERS(LAYERS), .MAX_ITER(MAX_ITER), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .start(start), .abort(abort), .busy(busy), .done(done),
    .converged(converged), .iter_cnt(iter_cnt), .shift_out(shift_out), .shift_valid(shift_valid),
    .shift_ready(shift_ready), .layer_idx(layer_idx), .col_idx(col_idx), .layer_last(layer_last),
    .syn_valid(syn_valid), .syn_ok(syn_ok));

  typedef struct {int sh; int ly; int cl; int last;} ent_t;

  int errors = 0, checks = 0;
  logic [7:0] mtbl [N];
  bit merr;
  ent_t exp_q[$];
  int pos;
  bit mon_en;
  int ready_mode;
  int last_iter;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       shift_ready = 1'b1;
      1:       shift_ready = !shift_ready;
      default: shift_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Per-cycle compare against the expected issue list.
  logic pv, pr, plast;
  logic [7:0] ps;
  logic [AW-1:0] pl, pc;
  always @(negedge clk) begin
    if (mon_en) begin
      if (pos < exp_q.size()) begin
        chk("valid_in_pass", shift_valid, 1);
        if (shift_valid) begin
          chk("shift_out", shift_out, exp_q[pos].sh);
          chk("layer_idx", layer_idx, exp_q[pos].ly);
          chk("col_idx", col_idx, exp_q[pos].cl);
          chk("layer_last", layer_last, exp_q[pos].last);
          if (shift_ready) pos++;
        end
      end else begin
        chk("no_extra_issue", shift_valid, 0);
      end
      if (pv && !pr)
        chk("hold_on_stall", {shift_valid, shift_out, layer_idx, col_idx, layer_last},
            {pv, ps, pl, pc, plast});
    end
    pv = shift_valid & mon_en; pr = shift_ready; ps = shift_out;
    pl = layer_idx; pc = col_idx; plast = layer_last;
  end

  function automatic void build_exp();
    exp_q.delete();
    for (int i = 0; i < N; i++)
      if (!(SKIP && mtbl[i] == 8'hFF))
        exp_q.push_back('{int'(mtbl[i]), i / D, i % D, int'((i % D) == D - 1)});
  endfunction

  task automatic wr(input int a, input int dv);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = 8'(dv);
    tick();
    cfg_we = 1'b0;
    if (a >= N) merr = 1'b1;
    else if (dv != 255 && (dv >> 2) >= D) begin mtbl[a] = 8'hFF; merr = 1'b1; end
    else mtbl[a] = 8'(dv);
    chk("cfg_err", cfg_err, merr);
  endtask

  task automatic begin_decode(input bit with_we);
    build_exp();
    mon_en = 1'b0;
    start = 1'b1;
    if (with_we) begin cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 8'h00; end
    tick();
    start = 1'b0; cfg_we = 1'b0;
    merr = with_we;
    pos = 0; mon_en = 1'b1;
    chk("busy_after_start", busy, 1);
    chk("cfg_err_at_start", cfg_err, merr);
    chk("iter_at_start", iter_cnt, 0);
    chk("first_valid", shift_valid, exp_q.size() > 0);
  endtask

  // conv_at: iteration whose syndrome passes (>= MAX_ITER means never).
  task automatic run_decode(input int conv_at, input bit with_we, input bit noise);
    bit ok;
    begin_decode(with_we);
    for (int it = 0; it < MAX_ITER; it++) begin
      int cyc = 0;
      while (pos < exp_q.size() && cyc < 2000) begin
        syn_valid = noise && ($urandom_range(0, 7) == 0);
        syn_ok = 1'($urandom);
        tick(); cyc++;
      end
      syn_valid = 1'b0; syn_ok = 1'b0;
      if (pos < exp_q.size()) begin
        chk("pass_timeout", pos, exp_q.size());
        mon_en = 1'b0; abort = 1'b1; tick(); abort = 1'b0; tick(); tick();
        return;
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        cfg_we = 1'b1; cfg_addr = AW'($urandom_range(0, N - 1)); cfg_data = 8'($urandom);
        tick(); cfg_we = 1'b0; merr = 1'b1;
        chk("cfg_we_busy_err", cfg_err, 1);
      end
      repeat ($urandom_range(0, 2)) tick();
      chk("wait_syn_busy", busy, 1);
      ok = (it == conv_at);
      syn_valid = 1'b1; syn_ok = ok;
      tick();
      syn_valid = 1'b0; syn_ok = 1'b0;
      if (ok || it == MAX_ITER - 1) begin
        mon_en = 1'b0;
        chk("done_pulse", done, 1);
        chk("converged", converged, ok);
        chk("iter_final", iter_cnt, it);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", shift_valid, 0);
        last_iter = it;
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("converged_hold", converged, ok);
        chk("cfg_err_hold", cfg_err, merr);
        return;
      end
      pos = 0;
      chk("iter_inc", iter_cnt, it + 1);
      chk("no_done_mid", done, 0);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) wr(i, (i % D) * 4);
  endtask

  initial begin
    int nff;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; abort = 1'b0;
    shift_ready = 1'b0; syn_valid = 1'b0; syn_ok = 1'b0; ready_mode = 0; mon_en = 1'b0; pos = 0;
    merr = 1'b0;
    for (int i = 0; i < N; i++) mtbl[i] = 8'hFF;
    #12;
    chk("rst_outputs", {busy, done, converged, iter_cnt, shift_out, shift_valid, layer_idx,
                        col_idx, layer_last, cfg_err}, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Pattern table, converge on first syndrome.
    fill_pattern();
    build_exp();
    chk("model_len", exp_q.size(), 20);
    chk("model_e7", exp_q[7].sh, 8);
    chk("model_e9_last", exp_q[9].last, 1);
    run_decode(0, 1'b0, 1'b0);
    chk("iter_conv0", last_iter, 0);

    // Never converges: iteration limit.
    run_decode(MAX_ITER + 5, 1'b0, 1'b0);
    chk("iter_limit", last_iter, 9);

    // Alternating ready.
    ready_mode = 1;
    run_decode(1, 1'b0, 1'b0);
    ready_mode = 0;

    // Illegal writes, then start clears the sticky error.
    wr(25, 8'h05);
    wr(6, 8'h14);
    chk("model_null_6", mtbl[6], 8'hFF);
    run_decode(0, 1'b0, 1'b0);
    wr(6, 8'h04);

    // Start together with a write: write dropped, error set.
    run_decode(0, 1'b1, 1'b0);

    // Abort in layer 2.
    build_exp();
    begin_decode(1'b0);
    for (int c = 0; c < 200 && exp_q[pos].ly < 2; c++) tick();
    mon_en = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_valid", shift_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_conv", converged, 0);
    chk("abort_busy", busy, 0);
    chk("abort_iter", iter_cnt, 0);
    tick();
    chk("abort_done_clr", done, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle_nop", {busy, done}, 0);

    // Null entries in layer 1.
    wr(6, 8'hFF); wr(8, 8'hFF);
    build_exp();
    nff = 0;
    foreach (exp_q[i]) if (exp_q[i].sh == 255) nff++;
    chk("model_null_len", exp_q.size(), SKIP ? 18 : 20);
    chk("model_null_ff", nff, SKIP ? 0 : 2);
    run_decode(0, 1'b0, 1'b0);

    // Async reset mid-run reinitialises outputs and table.
    build_exp();
    begin_decode(1'b0);
    repeat (4) tick();
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {busy, done, converged, iter_cnt, shift_out, shift_valid, layer_idx,
                         col_idx, layer_last, cfg_err}, 0);
    for (int i = 0; i < N; i++) mtbl[i] = 8'hFF;
    merr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    run_decode(1, 1'b0, 1'b0);

    // Random tables, ready patterns and syndrome outcomes.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(5, 30))
        wr($urandom_range(0, N + 3), ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 23));
      ready_mode = $urandom_range(0, 2);
      run_decode($urandom_range(0, MAX_ITER + 2), 1'($urandom_range(0, 5) == 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
